branch_resolve_unit: RTL and testbench

//   Multi-cycle branch resolution stage that sits directly downstream of the
//   64-bit ripple-borrow subtractor. It latches one conditional-branch request
//   (rs1, rs2, funct3, pc, imm) and drives the subtractor operands.
//   It waits a fixed settle window for the borrow chain, then samples the

---
 rtl/branch_resolve_if.sv | 36 +++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Bundle of the request, subtractor and result channels of the branch resolve stage.
// slave is the resolve unit's view; master is the view of the surrounding pipeline.
interface branch_resolve_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] sub_a;
  logic [XLEN-1:0] sub_b;
  logic [XLEN-1:0] sub_diff;
  logic            sub_borrow;
  logic            sub_overflow;
  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport slave (
    input  flush, in_valid, in_rs1, in_rs2, in_funct3, in_pc, in_imm,
           sub_diff, sub_borrow, sub_overflow, out_ready,
    output in_ready, sub_a, sub_b, out_valid, out_taken, out_target, out_illegal
  );

  modport master (
    output flush, in_valid, in_rs1, in_rs2, in_funct3, in_pc, in_imm,
           sub_diff, sub_borrow, sub_overflow, out_ready,
    input  in_ready, sub_a, sub_b, out_valid, out_taken, out_target, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Multi-cycle conditional-branch resolver: drives an external subtractor, waits for
// the borrow chain to settle, then decides taken/target and hands it off valid/ready.
module branch_resolve_unit #(
  parameter int XLEN          = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_resolve_if.slave bus
);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RESOLVE, HOLD} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [2:0]      funct3_q;
  logic            accept;
  logic            zero;
  logic            lt;
  logic            taken_d;
  logic            illegal_d;
  logic [XLEN-1:0] target_d;

  // in_ready drops while rst_n is low so nothing is accepted during reset.
  assign bus.in_ready = (state == IDLE) & rst_n;
  assign accept       = bus.in_valid & (state == IDLE) & ~bus.flush;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nxt = SETTLE;
      SETTLE:  if (cnt == CNT_W'(1)) state_nxt = RESOLVE;
      RESOLVE: state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Signed less-than from a subtractor: the sign of the difference is wrong exactly
  // when the subtraction overflowed.
  always_comb begin
    zero      = (bus.sub_diff == '0);
    lt        = bus.sub_diff[XLEN-1] ^ bus.sub_overflow;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    unique case (funct3_q)
      3'b000:  taken_d = zero;
      3'b001:  taken_d = ~zero;
      3'b100:  taken_d = lt;
      3'b101:  taken_d = ~lt;
      3'b110:  taken_d = bus.sub_borrow;
      3'b111:  taken_d = ~bus.sub_borrow;
      default: illegal_d = 1'b1;
    endcase
    target_d = taken_d ? (pc_q + imm_q) : (pc_q + XLEN'(4));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand registers only load on acceptance, keeping sub_a/sub_b stable until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sub_a <= '0;
      bus.sub_b <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      cnt       <= '0;
    end else if (accept) begin
      bus.sub_a <= bus.in_rs1;
      bus.sub_b <= bus.in_rs2;
      pc_q      <= bus.in_pc;
      imm_q     <= bus.in_imm;
      funct3_q  <= bus.in_funct3;
      cnt       <= CNT_W'(SETTLE_CYCLES);
    end else if (state == SETTLE) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_taken   <= 1'b0;
      bus.out_illegal <= 1'b0;
      bus.out_target  <= '0;
    end else if (bus.flush) begin
      bus.out_valid   <= 1'b0;
      bus.out_taken   <= 1'b0;
      bus.out_illegal <= 1'b0;
    end else if (state == RESOLVE) begin
      bus.out_valid   <= 1'b1;
      bus.out_taken   <= taken_d;
      bus.out_illegal <= illegal_d;
      bus.out_target  <= target_d;
    end else if (state == HOLD && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a behavioural 64-bit subtractor
// attached to sub_a/sub_b and hand-computed expected results.
module tb_branch_resolve_unit;
  localparam int XLEN   = 64;
  localparam int SETTLE = 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_resolve_if #(.XLEN(XLEN)) bus ();

  branch_resolve_unit #(.XLEN(XLEN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream subtractor: borrow is the unsigned a<b flag, overflow the signed one.
  logic [XLEN:0] wide;
  always_comb begin
    wide             = {1'b0, bus.sub_a} - {1'b0, bus.sub_b};
    bus.sub_diff     = wide[XLEN-1:0];
    bus.sub_borrow   = wide[XLEN];
    bus.sub_overflow = (bus.sub_a[XLEN-1] ^ bus.sub_b[XLEN-1]) & (wide[XLEN-1] ^ bus.sub_a[XLEN-1]);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [63:0] rs1, input logic [63:0] rs2, input logic [2:0] f3,
                       input logic [63:0] pc, input logic [63:0] imm);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_pc     = pc;
    bus.in_imm    = imm;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("accept_in_ready", 64'(bus.in_ready), 64'd0);
    check("sub_a", bus.sub_a, rs1);
    check("sub_b", bus.sub_b, rs2);
  endtask

  task automatic await_result(input string tag, input logic exp_taken,
                              input logic [63:0] exp_target, input logic exp_illegal);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(SETTLE + 1));
    check({tag, "_taken"}, 64'(bus.out_taken), 64'(exp_taken));
    check({tag, "_target"}, bus.out_target, exp_target);
    check({tag, "_illegal"}, 64'(bus.out_illegal), 64'(exp_illegal));
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_retire_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_retire_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic branch(input string tag, input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [2:0] f3, input logic [63:0] pc, input logic [63:0] imm,
                        input logic exp_taken, input logic [63:0] exp_target, input logic exp_illegal);
    issue(rs1, rs2, f3, pc, imm);
    await_result(tag, exp_taken, exp_target, exp_illegal);
    retire(tag);
  endtask

  initial begin
    bit saw_valid;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_pc     = '0;
    bus.in_imm    = '0;
    bus.out_ready = 1'b0;

    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_taken", 64'(bus.out_taken), 64'd0);
    check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_out_target", bus.out_target, 64'd0);
    check("rst_sub_a", bus.sub_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Basic taken/not-taken cases across all six branch types.
    branch("beq", 64'd5, 64'd5, 3'b000, 64'h1000, 64'h20, 1'b1, 64'h1020, 1'b0);
    branch("blt_neg", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b100, 64'h2000, 64'h40, 1'b1, 64'h2040, 1'b0);
    branch("bltu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b110, 64'h2000, 64'h40, 1'b0, 64'h2004, 1'b0);
    branch("blt_ovf", 64'h8000_0000_0000_0000, 64'd1, 3'b100, 64'h3000, 64'h100, 1'b1, 64'h3100, 1'b0);
    branch("bge_ovf", 64'h8000_0000_0000_0000, 64'd1, 3'b101, 64'h3000, 64'h100, 1'b0, 64'h3004, 1'b0);
    branch("bgeu", 64'd10, 64'd3, 3'b111, 64'h6000, 64'h10, 1'b1, 64'h6010, 1'b0);
    branch("bne_eq", 64'd9, 64'd9, 3'b001, 64'h7000, 64'h80, 1'b0, 64'h7004, 1'b0);
    branch("illegal010", 64'd1, 64'd1, 3'b010, 64'h5000, 64'h8, 1'b0, 64'h5004, 1'b1);
    branch("illegal011", 64'd1, 64'd2, 3'b011, 64'h5100, 64'h8, 1'b0, 64'h5104, 1'b1);
    branch("bne_wrap", 64'd1, 64'd2, 3'b001, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1, 64'h4, 1'b0);

    // Consumer back-pressure: result must hold still and no new request accepted.
    issue(64'd7, 64'd3, 3'b001, 64'h4000, 64'hFFFF_FFFF_FFFF_FFF0);
    await_result("hold", 1'b1, 64'h3FF0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_taken", 64'(bus.out_taken), 64'd1);
      check("hold_target", bus.out_target, 64'h3FF0);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    retire("hold");

    // Flush while the subtractor is settling.
    issue(64'd5, 64'd5, 3'b000, 64'h1000, 64'h20);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush_settle_in_ready", 64'(bus.in_ready), 64'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      saw_valid |= bus.out_valid;
    end
    check("flush_settle_no_valid", 64'(saw_valid), 64'd0);

    // Flush in IDLE together with in_valid must not accept.
    @(negedge clk);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_rs1   = 64'hDEAD;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_idle_sub_a", bus.sub_a, 64'd5);

    // Flush in HOLD concurrent with out_ready drops the result.
    issue(64'd1, 64'd2, 3'b001, 64'h8000, 64'h10);
    await_result("flush_hold", 1'b1, 64'h8010, 1'b0);
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_hold_valid", 64'(bus.out_valid), 64'd0);
    check("flush_hold_taken", 64'(bus.out_taken), 64'd0);
    check("flush_hold_in_ready", 64'(bus.in_ready), 64'd1);

    // Asynchronous reset while in RESOLVE.
    issue(64'd5, 64'd5, 3'b000, 64'h1000, 64'h20);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check("arst_sub_a", bus.sub_a, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      saw_valid |= bus.out_valid;
    end
    check("arst_no_valid", 64'(saw_valid), 64'd0);
    check("arst_in_ready_after", 64'(bus.in_ready), 64'd1);

    branch("beq_again", 64'd5, 64'd5, 3'b000, 64'h1000, 64'h20, 1'b1, 64'h1020, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
